// File: rtl/vpu_pkg.sv
// Shared types for the VPU lane ALU: opcode encoding, FSM states and shifter type codes.
package vpu_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_MAX  = 4'd7,
    OP_MIN  = 4'd8,
    OP_SLL  = 4'd9,
    OP_SRL  = 4'd10,
    OP_SRA  = 4'd11,
    OP_MUL  = 4'd12,
    OP_MULH = 4'd13
  } vpu_alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

endpackage

// File: rtl/vpu_bshifter.sv
// Combinational barrel shifter: type 00/01 SLL, 10 SRL, 11 SRA (fills with data MSB).
// Zero latency, no flow control.
module vpu_bshifter #(
  parameter int XLEN = 16
) (
  input  logic [1:0]              sh_type_i,
  input  logic [XLEN-1:0]         data_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  output logic [XLEN-1:0]         res_o
);

  always_comb begin
    case (sh_type_i)
      2'b10:   res_o = data_i >> shamt_i;
      2'b11:   res_o = $signed(data_i) >>> shamt_i;
      default: res_o = data_i << shamt_i;
    endcase
  end

endmodule

// File: rtl/vpu_alu_pipe.sv
// Lane ALU with single-entry output register: 1-cycle ops in 1 cycle, MUL/MULH in XLEN+1 cycles.
// Stalled output holds result and drops in_ready; no accepts while the multiplier iterates.
module vpu_alu_pipe
  import vpu_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            unsign,
  input  logic [XLEN-1:0] ds1,
  input  logic [XLEN-1:0] ds2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            gt,
  output logic            eq,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int PW  = 2 * XLEN;

  alu_state_t      state_q;
  logic            rdy_en_q;
  logic            out_valid_q, gt_q, eq_q;
  logic [XLEN-1:0] result_q;
  logic [SHW-1:0]  cnt_q;
  logic [PW-1:0]   acc_q, mcand_q;
  logic [XLEN-1:0] mplr_q;
  logic            neg_q, high_q, pgt_q, peq_q;

  logic            accept, is_mul, is_sub, sgn_diff, lt_c, gt_c, eq_c;
  logic            a_neg, b_neg, last;
  logic [1:0]      sh_type;
  logic [XLEN-1:0] addsub, sh_res, alu_res, a_mag, b_mag, mul_res;
  logic [PW-1:0]   acc_nxt, prod_fix;

  // Signed compare only differs from unsigned when the operand signs differ.
  assign sgn_diff = ds1[XLEN-1] ^ ds2[XLEN-1];
  assign lt_c     = (!unsign && sgn_diff) ? ds1[XLEN-1] : (ds1 < ds2);
  assign gt_c     = (!unsign && sgn_diff) ? ds2[XLEN-1] : (ds1 > ds2);
  assign eq_c     = (ds1 == ds2);

  assign is_sub = (op == OP_SUB);
  assign addsub = ds1 + (is_sub ? ~ds2 : ds2) + XLEN'(is_sub);

  assign sh_type = (op == OP_SRA) ? SH_SRA : (op == OP_SRL) ? SH_SRL : SH_SLL;

  vpu_bshifter #(.XLEN(XLEN)) u_shift (
    .sh_type_i (sh_type),
    .data_i    (ds1),
    .shamt_i   (ds2[SHW-1:0]),
    .res_o     (sh_res)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_PASS:               alu_res = ds1;
      OP_ADD, OP_SUB:        alu_res = addsub;
      OP_AND:                alu_res = ds1 & ds2;
      OP_OR:                 alu_res = ds1 | ds2;
      OP_XOR:                alu_res = ds1 ^ ds2;
      OP_SLT:                alu_res = XLEN'(lt_c);
      OP_MAX:                alu_res = gt_c ? ds1 : ds2;
      OP_MIN:                alu_res = lt_c ? ds1 : ds2;
      OP_SLL, OP_SRL, OP_SRA: alu_res = sh_res;
      default:               alu_res = '0;
    endcase
  end

  // Magnitudes are XLEN-bit unsigned, so abs(-2^(XLEN-1)) = 2^(XLEN-1) is exact.
  assign is_mul = (op == OP_MUL) || (op == OP_MULH);
  assign a_neg  = !unsign && ds1[XLEN-1];
  assign b_neg  = !unsign && ds2[XLEN-1];
  assign a_mag  = a_neg ? -ds1 : ds1;
  assign b_mag  = b_neg ? -ds2 : ds2;

  assign acc_nxt  = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign prod_fix = neg_q ? -acc_nxt : acc_nxt;
  assign mul_res  = high_q ? prod_fix[PW-1:XLEN] : prod_fix[XLEN-1:0];
  assign last     = (cnt_q == SHW'(XLEN - 1));

  assign in_ready = rdy_en_q && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      neg_q       <= 1'b0;
      high_q      <= 1'b0;
      pgt_q       <= 1'b0;
      peq_q       <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= ST_MUL;
              cnt_q   <= '0;
              acc_q   <= '0;
              mcand_q <= {{XLEN{1'b0}}, a_mag};
              mplr_q  <= b_mag;
              neg_q   <= a_neg ^ b_neg;
              high_q  <= (op == OP_MULH);
              pgt_q   <= gt_c;
              peq_q   <= eq_c;
            end else begin
              result_q    <= alu_res;
              gt_q        <= gt_c;
              eq_q        <= eq_c;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_q   <= acc_nxt;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + SHW'(1);
          if (last) begin
            result_q    <= mul_res;
            gt_q        <= pgt_q;
            eq_q        <= peq_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_vpu_alu_pipe.sv
// Self-checking bench for vpu_alu_pipe (XLEN=16): directed vectors, random ops vs arithmetic model,
// backpressure and reset-during-multiply scenarios.
module tb_vpu_alu_pipe;
  import vpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic        unsign = 1'b0;
  logic [15:0] ds1 = 16'd0;
  logic [15:0] ds2 = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        gt, eq, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  o;
    bit          u;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    bit          g;
    bit          e;
  } vec_t;

  vpu_alu_pipe #(.XLEN(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .unsign    (unsign),
    .ds1       (ds1),
    .ds2       (ds2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .gt        (gt),
    .eq        (eq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: operands interpreted as integers, results taken modulo 2^16.
  function automatic logic [15:0] ref_res(input logic [3:0] o, input bit u,
                                          input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p;
    int sh;
    sa = u ? longint'(a) : longint'($signed(a));
    sb = u ? longint'(b) : longint'($signed(b));
    sh = int'(b[3:0]);
    case (o)
      4'd0:  return a;
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return (sa < sb) ? 16'd1 : 16'd0;
      4'd7:  return (sa > sb) ? a : b;
      4'd8:  return (sa < sb) ? a : b;
      4'd9:  return a << sh;
      4'd10: return a >> sh;
      4'd11: begin p = longint'($signed(a)) >>> sh; return p[15:0]; end
      4'd12: begin p = sa * sb; return p[15:0]; end
      4'd13: begin p = sa * sb; return p[31:16]; end
      default: return 16'd0;
    endcase
  endfunction

  function automatic bit ref_gt(input bit u, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb;
    sa = u ? longint'(a) : longint'($signed(a));
    sb = u ? longint'(b) : longint'($signed(b));
    return sa > sb;
  endfunction

  // Presents one op and returns just after the accepting edge.
  task automatic send(input logic [3:0] o, input bit u, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    @(negedge clk);
    op = o; unsign = u; ds1 = a; ds2 = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_accept: in_ready=%0b required=1 after %0d cycles", in_ready, n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Waits for out_valid (counting cycles since accept), samples, then completes the handshake.
  task automatic collect(output logic [15:0] r, output bit g, output bit e, output int lat);
    lat = 0;
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    r = result; g = gt; e = eq;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, result, gt, eq, busy} !== 20'd0) begin
      failures++;
      $display("FAIL reset_state: ov=%0b res=%h gt=%0b eq=%0b busy=%0b required all zero",
               out_valid, result, gt, eq, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic run_table(input string name, input vec_t t[$], input int exp_lat);
    logic [15:0] r;
    bit g, e;
    int lat;
    foreach (t[i]) begin
      send(t[i].o, t[i].u, t[i].a, t[i].b);
      collect(r, g, e, lat);
      checks++;
      if (r !== t[i].r || g !== t[i].g || e !== t[i].e || lat != exp_lat) begin
        failures++;
        $display("FAIL %s[%0d]: res=%h gt=%0b eq=%0b lat=%0d required res=%h gt=%0b eq=%0b lat=%0d",
                 name, i, r, g, e, lat, t[i].r, t[i].g, t[i].e, exp_lat);
      end
    end
  endtask

  task automatic test_single_cycle;
    vec_t t[$];
    t.push_back('{OP_ADD,  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0});
    t.push_back('{OP_SUB,  1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0});
    t.push_back('{OP_SLT,  1'b0, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0});
    t.push_back('{OP_SLT,  1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});
    t.push_back('{OP_SRA,  1'b0, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0});
    t.push_back('{OP_SRL,  1'b1, 16'h8000, 16'h000F, 16'h0001, 1'b1, 1'b0});
    t.push_back('{OP_SLL,  1'b1, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0});
    t.push_back('{OP_XOR,  1'b0, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b1});
    t.push_back('{OP_MAX,  1'b0, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0});
    t.push_back('{OP_MIN,  1'b1, 16'h8000, 16'h0001, 16'h0001, 1'b1, 1'b0});
    t.push_back('{4'd14,   1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0});
    run_table("single", t, 1);
  endtask

  task automatic test_mul;
    vec_t t[$];
    int stall_bad = 0;
    int lat = 0;
    t.push_back('{OP_MUL,  1'b1, 16'h1234, 16'h0010, 16'h2340, 1'b1, 1'b0});
    t.push_back('{OP_MULH, 1'b1, 16'h1234, 16'h0010, 16'h0001, 1'b1, 1'b0});
    t.push_back('{OP_MULH, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1});
    t.push_back('{OP_MUL,  1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1});
    t.push_back('{OP_MULH, 1'b0, 16'h8000, 16'h8000, 16'h4000, 1'b0, 1'b1});
    t.push_back('{OP_MULH, 1'b0, 16'h7FFF, 16'h8000, 16'hC000, 1'b1, 1'b0});
    t.push_back('{OP_MUL,  1'b0, 16'h7FFF, 16'h8000, 16'h8000, 1'b1, 1'b0});
    t.push_back('{OP_MULH, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1});
    run_table("mul", t, 17);
    // While iterating: no accept possible, busy high.
    send(OP_MUL, 1'b1, 16'h0003, 16'h0005);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && (in_ready !== 1'b0 || busy !== 1'b1)) stall_bad++;
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    checks++;
    if (stall_bad != 0 || result !== 16'h000F || lat != 17) begin
      failures++;
      $display("FAIL mul_busy: bad_cycles=%0d res=%h lat=%0d required 0/000f/17", stall_bad, result, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [15:0] a, b, r;
    logic [3:0] o;
    bit u, g, e;
    int lat, exp_lat;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      u = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
      exp_lat = (o == OP_MUL || o == OP_MULH) ? 17 : 1;
      send(o, u, a, b);
      collect(r, g, e, lat);
      checks++;
      if (r !== ref_res(o, u, a, b) || g !== ref_gt(u, a, b) || e !== (a == b) || lat != exp_lat) begin
        failures++;
        $display("FAIL random[%0d] op=%0d u=%0b a=%h b=%h: res=%h gt=%0b eq=%0b lat=%0d required res=%h gt=%0b eq=%0b lat=%0d",
                 i, o, u, a, b, r, g, e, lat, ref_res(o, u, a, b), ref_gt(u, a, b), (a == b), exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r1, r2;
    r1 = 16'h1111 + 16'h2222;
    r2 = 16'hF000 + 16'h1001;
    @(negedge clk);
    out_ready = 1'b0;
    op = OP_ADD; unsign = 1'b0; ds1 = 16'h1111; ds2 = 16'h2222; in_valid = 1'b1;
    @(posedge clk);
    #1 ds1 = 16'hF000; ds2 = 16'h1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== r1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall[%0d]: ov=%0b res=%h in_ready=%0b required 1/%h/0", k, out_valid, result, in_ready, r1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== r2) begin
      failures++;
      $display("FAIL b2b_second: ov=%0b res=%h required 1/%h", out_valid, result, r2);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_dup: ov=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [15:0] r;
    bit g, e;
    int lat, seen = 0;
    send(OP_MUL, 1'b1, 16'h00FF, 16'h00FF);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%0b ov=%0b required 0/0", busy, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_reset_discard: out_valid cycles=%0d required 0", seen);
    end
    send(OP_ADD, 1'b0, 16'h0102, 16'h0304);
    collect(r, g, e, lat);
    checks++;
    if (r !== 16'h0406 || lat != 1) begin
      failures++;
      $display("FAIL post_reset_add: res=%h lat=%0d required 0406/1", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_random();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
